// File: rtl/ttt_pkg.sv
// Shared encodings and constants for the Tic Tac Toe turn controller.
// Line masks are listed in win_line bit order.
package ttt_pkg;

    typedef enum logic [1:0] {
        GS_OVER  = 2'd0,
        GS_P1    = 2'd1,
        GS_P2    = 2'd2,
        GS_CHECK = 2'd3
    } game_state_e;

    localparam logic [3:0]  NO_CELL   = 4'd15;
    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned NUM_LINES = 8;

    localparam logic [NUM_CELLS-1:0] LINE_MASKS [NUM_LINES] = '{
        9'b000_000_111,  // row 012
        9'b000_111_000,  // row 345
        9'b111_000_000,  // row 678
        9'b001_001_001,  // col 036
        9'b010_010_010,  // col 147
        9'b100_100_100,  // col 258
        9'b100_010_001,  // diag 048
        9'b001_010_100   // diag 246
    };

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/ttt_line_checker.sv
// Combinational three-in-a-row detector for a single player's cell mask.
module ttt_line_checker
    import ttt_pkg::*;
(
    input  logic [NUM_CELLS-1:0] mask,
    output logic [NUM_LINES-1:0] line_hit,
    output logic                 any_win
);

    always_comb begin
        line_hit = '0;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            line_hit[i] = ((mask & LINE_MASKS[i]) == LINE_MASKS[i]);
        end
        any_win = |line_hit;
    end

endmodule

// File: rtl/ttt_turn_controller.sv
// Turn sequencer and referee: arbitrates move requests, commits legal moves
// to the board register, and evaluates win/draw one cycle after each commit.
module ttt_turn_controller
    import ttt_pkg::*;
#(
    parameter int unsigned FIRST_PLAYER    = 1,
    parameter int unsigned ALTERNATE_START = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       p1_req,
    input  logic [3:0] p1_coord,
    input  logic       p2_req,
    input  logic [3:0] p2_coord,
    output logic [1:0] game_state,
    output logic [8:0] board_occ,
    output logic [8:0] board_owner,
    output logic       move_ack,
    output logic       move_rej,
    output logic [3:0] last_move,
    output logic       win_signal,
    output logic [1:0] winner,
    output logic [7:0] win_line,
    output logic       draw,
    output logic [3:0] p1_wins,
    output logic [3:0] p2_wins,
    output logic [3:0] draws
);

    localparam logic        FIRST_P2    = (FIRST_PLAYER == 2);
    localparam game_state_e FIRST_STATE = FIRST_P2 ? GS_P2 : GS_P1;

    game_state_e state_q, state_d;
    logic        starter_p2_q, starter_p2_d;
    logic        mover_p2_q, mover_p2_d;
    logic [8:0]  occ_q, occ_d, owner_q, owner_d;
    logic [3:0]  last_move_q, last_move_d;
    logic        ack_q, ack_d, rej_q, rej_d, rej_pend_q, rej_pend_d;
    logic        win_q, win_d, draw_q, draw_d;
    logic [1:0]  winner_q, winner_d;
    logic [7:0]  win_line_q, win_line_d;
    logic [3:0]  p1w_q, p1w_d, p2w_q, p2w_d, draws_q, draws_d;

    logic        cur_p2, cur_req, oth_req, legal;
    logic [3:0]  cur_coord;
    logic [8:0]  cell_onehot, mover_mask;
    logic [7:0]  line_hit;
    logic        any_win;

    assign mover_mask = mover_p2_q ? (occ_q & owner_q) : (occ_q & ~owner_q);

    ttt_line_checker u_line_checker (
        .mask     (mover_mask),
        .line_hit (line_hit),
        .any_win  (any_win)
    );

    always_comb begin
        state_d      = state_q;
        starter_p2_d = starter_p2_q;
        mover_p2_d   = mover_p2_q;
        occ_d        = occ_q;
        owner_d      = owner_q;
        last_move_d  = last_move_q;
        ack_d        = 1'b0;
        rej_d        = 1'b0;
        rej_pend_d   = 1'b0;
        win_d        = win_q;
        draw_d       = draw_q;
        winner_d     = winner_q;
        win_line_d   = win_line_q;
        p1w_d        = p1w_q;
        p2w_d        = p2w_q;
        draws_d      = draws_q;

        cur_p2      = (state_q == GS_P2);
        cur_req     = cur_p2 ? p2_req : p1_req;
        oth_req     = cur_p2 ? p1_req : p2_req;
        cur_coord   = cur_p2 ? p2_coord : p1_coord;
        // Shifting past bit 8 yields zero, so off-board coords never alias a cell.
        cell_onehot = 9'b1 << cur_coord;
        legal       = (cur_coord <= 4'd8) && ((occ_q & cell_onehot) == '0);

        if (new_game) begin
            occ_d        = '0;
            owner_d      = '0;
            last_move_d  = NO_CELL;
            win_d        = 1'b0;
            draw_d       = 1'b0;
            winner_d     = 2'd0;
            win_line_d   = '0;
            starter_p2_d = (ALTERNATE_START == 1) ? ~starter_p2_q : FIRST_P2;
            state_d      = starter_p2_d ? GS_P2 : GS_P1;
        end else begin
            case (state_q)
                GS_P1, GS_P2: begin
                    if (cur_req && legal) begin
                        occ_d       = occ_q | cell_onehot;
                        owner_d     = cur_p2 ? (owner_q | cell_onehot) : (owner_q & ~cell_onehot);
                        last_move_d = cur_coord;
                        mover_p2_d  = cur_p2;
                        ack_d       = 1'b1;
                        state_d     = GS_CHECK;
                        // A simultaneous out-of-turn request is refused one cycle later so
                        // move_rej never coincides with move_ack.
                        rej_pend_d  = oth_req;
                    end else begin
                        rej_d = cur_req | oth_req;
                    end
                end
                GS_CHECK: begin
                    rej_d = p1_req | p2_req | rej_pend_q;
                    if (any_win) begin
                        win_d      = 1'b1;
                        winner_d   = mover_p2_q ? 2'd2 : 2'd1;
                        win_line_d = line_hit;
                        if (mover_p2_q) p2w_d = sat_inc(p2w_q);
                        else            p1w_d = sat_inc(p1w_q);
                        state_d    = GS_OVER;
                    end else if (&occ_q) begin
                        draw_d  = 1'b1;
                        draws_d = sat_inc(draws_q);
                        state_d = GS_OVER;
                    end else begin
                        state_d = mover_p2_q ? GS_P1 : GS_P2;
                    end
                end
                default: rej_d = p1_req | p2_req;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FIRST_STATE;
            starter_p2_q <= FIRST_P2;
            mover_p2_q   <= 1'b0;
            occ_q        <= '0;
            owner_q      <= '0;
            last_move_q  <= NO_CELL;
            ack_q        <= 1'b0;
            rej_q        <= 1'b0;
            rej_pend_q   <= 1'b0;
            win_q        <= 1'b0;
            draw_q       <= 1'b0;
            winner_q     <= 2'd0;
            win_line_q   <= '0;
            p1w_q        <= '0;
            p2w_q        <= '0;
            draws_q      <= '0;
        end else begin
            state_q      <= state_d;
            starter_p2_q <= starter_p2_d;
            mover_p2_q   <= mover_p2_d;
            occ_q        <= occ_d;
            owner_q      <= owner_d;
            last_move_q  <= last_move_d;
            ack_q        <= ack_d;
            rej_q        <= rej_d;
            rej_pend_q   <= rej_pend_d;
            win_q        <= win_d;
            draw_q       <= draw_d;
            winner_q     <= winner_d;
            win_line_q   <= win_line_d;
            p1w_q        <= p1w_d;
            p2w_q        <= p2w_d;
            draws_q      <= draws_d;
        end
    end

    assign game_state  = state_q;
    assign board_occ   = occ_q;
    assign board_owner = owner_q;
    assign move_ack    = ack_q;
    assign move_rej    = rej_q;
    assign last_move   = last_move_q;
    assign win_signal  = win_q;
    assign winner      = winner_q;
    assign win_line    = win_line_q;
    assign draw        = draw_q;
    assign p1_wins     = p1w_q;
    assign p2_wins     = p2w_q;
    assign draws       = draws_q;

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Self-checking bench: directed game scenarios plus randomized play, all
// compared against a cell-array game model.
module tb_ttt_turn_controller;

    localparam int FIRST = 1;
    localparam int ALT   = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       new_game = 1'b0;
    logic       p1_req = 1'b0;
    logic [3:0] p1_coord = 4'd0;
    logic       p2_req = 1'b0;
    logic [3:0] p2_coord = 4'd0;
    logic [1:0] game_state;
    logic [8:0] board_occ, board_owner;
    logic       move_ack, move_rej;
    logic [3:0] last_move;
    logic       win_signal;
    logic [1:0] winner;
    logic [7:0] win_line;
    logic       draw;
    logic [3:0] p1_wins, p2_wins, draws;

    ttt_turn_controller #(.FIRST_PLAYER(FIRST), .ALTERNATE_START(ALT)) dut (
        .clk(clk), .rst(rst), .new_game(new_game),
        .p1_req(p1_req), .p1_coord(p1_coord), .p2_req(p2_req), .p2_coord(p2_coord),
        .game_state(game_state), .board_occ(board_occ), .board_owner(board_owner),
        .move_ack(move_ack), .move_rej(move_rej), .last_move(last_move),
        .win_signal(win_signal), .winner(winner), .win_line(win_line), .draw(draw),
        .p1_wins(p1_wins), .p2_wins(p2_wins), .draws(draws)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Game model: board cells hold 0 (empty), 1 (P1) or 2 (P2); m_state 0 = over, 1/2 = turn.
    int m_board[9];
    int m_state, m_starter, m_p1w, m_p2w, m_dr, m_winner, m_last;
    logic [7:0] m_wl;
    bit m_draw;
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    bit last_ack, last_rej1, last_rej2;

    function automatic logic [8:0] exp_occ();
        logic [8:0] r;
        for (int i = 0; i < 9; i++) r[i] = (m_board[i] != 0);
        return r;
    endfunction

    function automatic logic [8:0] exp_owner();
        logic [8:0] r;
        for (int i = 0; i < 9; i++) r[i] = (m_board[i] == 2);
        return r;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 9; i++) m_board[i] = 0;
        m_winner = 0; m_wl = '0; m_draw = 0; m_last = 15;
    endfunction

    task automatic do_reset();
        logic [41:0] got, exp;
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        m_state = FIRST; m_starter = FIRST; m_p1w = 0; m_p2w = 0; m_dr = 0;
        got = {game_state, board_occ, board_owner, move_ack, move_rej, last_move, win_signal,
               winner, win_line, draw, p1_wins, p2_wins, draws};
        exp = {2'(FIRST), 9'h0, 9'h0, 1'b0, 1'b0, 4'd15, 1'b0, 2'd0, 8'h0, 1'b0, 4'd0, 4'd0, 4'd0};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_state: got %h exp %h", got, exp);
        end
    endtask

    // who: bit0 = P1 requests, bit1 = P2 requests.
    task automatic req(input int who, input int c1, input int c2);
        bit commit, rej1, rej2, mine, other;
        int c, mover;
        logic [7:0] wl;
        logic [25:0] g1, e1;
        logic [27:0] g2, e2;
        bit full;
        @(negedge clk);
        p1_req = (who & 1) != 0; p1_coord = 4'(c1);
        p2_req = (who & 2) != 0; p2_coord = 4'(c2);
        commit = 0; rej1 = 0; rej2 = 0; c = 0; mover = m_state;
        if (m_state == 0) begin
            rej1 = (who != 0);
        end else begin
            mine  = (m_state == 1) ? ((who & 1) != 0) : ((who & 2) != 0);
            other = (m_state == 1) ? ((who & 2) != 0) : ((who & 1) != 0);
            c     = (m_state == 1) ? c1 : c2;
            if (mine && c < 9 && m_board[c] == 0) begin
                commit = 1; rej2 = other;
            end else begin
                rej1 = mine || other;
            end
        end
        @(negedge clk);
        p1_req = 1'b0; p2_req = 1'b0;
        if (commit) begin
            m_board[c] = mover; m_last = c;
        end
        g1 = {move_ack, move_rej, game_state, board_occ, board_owner, last_move};
        e1 = {commit, rej1, commit ? 2'd3 : 2'(m_state), exp_occ(), exp_owner(), 4'(m_last)};
        last_ack = move_ack; last_rej1 = move_rej;
        checks++;
        if (g1 !== e1) begin
            failures++;
            $display("FAIL move_n1 (who=%0d c1=%0d c2=%0d): got %h exp %h", who, c1, c2, g1, e1);
        end
        if (commit) begin
            wl = '0;
            for (int l = 0; l < 8; l++)
                if (m_board[lines[l][0]] == mover && m_board[lines[l][1]] == mover &&
                    m_board[lines[l][2]] == mover) wl[l] = 1'b1;
            full = 1;
            for (int i = 0; i < 9; i++) if (m_board[i] == 0) full = 0;
            if (wl != 0) begin
                m_winner = mover; m_wl = wl; m_state = 0;
                if (mover == 1 && m_p1w < 15) m_p1w++;
                if (mover == 2 && m_p2w < 15) m_p2w++;
            end else if (full) begin
                m_draw = 1; m_state = 0;
                if (m_dr < 15) m_dr++;
            end else begin
                m_state = 3 - mover;
            end
        end
        @(negedge clk);
        g2 = {game_state, win_signal, winner, win_line, draw, p1_wins, p2_wins, draws, move_rej, move_ack};
        e2 = {2'(m_state), m_winner != 0, 2'(m_winner), m_wl, m_draw, 4'(m_p1w), 4'(m_p2w),
              4'(m_dr), rej2, 1'b0};
        last_rej2 = move_rej;
        checks++;
        if (g2 !== e2) begin
            failures++;
            $display("FAIL move_n2 (who=%0d c1=%0d c2=%0d): got %h exp %h", who, c1, c2, g2, e2);
        end
    endtask

    task automatic play(input int c);
        req((m_state == 2) ? 2 : 1, c, c);
    endtask

    task automatic do_new_game(input bit with_p2);
        logic [43:0] got, exp;
        @(negedge clk);
        new_game = 1'b1; p2_req = with_p2; p2_coord = 4'd0;
        @(negedge clk);
        new_game = 1'b0; p2_req = 1'b0;
        m_starter = (ALT == 1) ? 3 - m_starter : FIRST;
        m_state = m_starter;
        model_clear();
        got = {game_state, board_occ, board_owner, last_move, win_signal, winner, win_line,
               draw, move_ack, p1_wins, p2_wins, draws};
        exp = {2'(m_state), 9'h0, 9'h0, 4'd15, 1'b0, 2'd0, 8'h0, 1'b0, 1'b0,
               4'(m_p1w), 4'(m_p2w), 4'(m_dr)};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL new_game: got %h exp %h", got, exp);
        end
    endtask

    task automatic win_p1();
        if (m_state == 1) begin
            play(0); play(3); play(1); play(4); play(2);
        end else begin
            play(3); play(0); play(4); play(1); play(8); play(2);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_p1_top_row();
        do_reset();
        play(0); play(4); play(1); play(5); play(2);
        checks++;
        if (winner !== 2'd1 || win_line !== 8'b0000_0001 || game_state !== 2'd0 || p1_wins !== 4'd1) begin
            failures++;
            $display("FAIL top_row: got winner=%0d line=%b gs=%0d p1w=%0d exp 1 00000001 0 1",
                     winner, win_line, game_state, p1_wins);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        play(4);
        play(4);
        checks++;
        if (last_rej1 !== 1'b1 || game_state !== 2'd2) begin
            failures++;
            $display("FAIL occupied: got rej=%0b gs=%0d exp 1 2", last_rej1, game_state);
        end
        play(15);
        checks++;
        if (last_rej1 !== 1'b1 || board_occ !== 9'h010) begin
            failures++;
            $display("FAIL off_board: got rej=%0b occ=%h exp 1 010", last_rej1, board_occ);
        end
    endtask

    task automatic test_out_of_turn();
        do_reset();
        req(2, 0, 3);
        checks++;
        if (last_rej1 !== 1'b1 || board_occ !== 9'h000) begin
            failures++;
            $display("FAIL out_of_turn: got rej=%0b occ=%h exp 1 000", last_rej1, board_occ);
        end
        req(3, 0, 3);
        checks++;
        if (last_ack !== 1'b1 || board_occ !== 9'h001 || (int'(last_rej1) + int'(last_rej2)) != 1) begin
            failures++;
            $display("FAIL simultaneous: got ack=%0b occ=%h rej=%0b%0b exp ack=1 occ=001 one rej",
                     last_ack, board_occ, last_rej1, last_rej2);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk); p1_req = 1'b1; p1_coord = 4'd0;
        @(negedge clk); p1_req = 1'b0; p2_req = 1'b1; p2_coord = 4'd1;
        checks++;
        if (move_ack !== 1'b1 || game_state !== 2'd3) begin
            failures++;
            $display("FAIL b2b_ack: got ack=%0b gs=%0d exp 1 3", move_ack, game_state);
        end
        @(negedge clk); p2_req = 1'b0;
        m_board[0] = 1; m_last = 0; m_state = 2;
        checks++;
        if (move_rej !== 1'b1 || game_state !== 2'd2 || board_occ !== 9'h001) begin
            failures++;
            $display("FAIL b2b_check_req: got rej=%0b gs=%0d occ=%h exp 1 2 001",
                     move_rej, game_state, board_occ);
        end
    endtask

    task automatic test_draw();
        int seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        do_reset();
        foreach (seq[i]) play(seq[i]);
        checks++;
        if (draw !== 1'b1 || win_signal !== 1'b0 || draws !== 4'd1 || board_occ !== 9'h1FF) begin
            failures++;
            $display("FAIL draw: got draw=%0b win=%0b draws=%0d occ=%h exp 1 0 1 1ff",
                     draw, win_signal, draws, board_occ);
        end
    endtask

    task automatic test_ninth_win();
        int seq[9] = '{0, 2, 1, 3, 4, 5, 6, 7, 8};
        do_reset();
        foreach (seq[i]) play(seq[i]);
        checks++;
        if (win_signal !== 1'b1 || winner !== 2'd1 || win_line !== 8'b0100_0000 || draw !== 1'b0) begin
            failures++;
            $display("FAIL ninth_win: got win=%0b winner=%0d line=%b draw=%0b exp 1 1 01000000 0",
                     win_signal, winner, win_line, draw);
        end
    endtask

    task automatic test_newgame_sat();
        do_reset();
        play(0); play(4); play(1); play(5); play(2);
        do_new_game(1'b1);
        checks++;
        if (game_state !== 2'd2 || board_occ !== 9'h000 || move_ack !== 1'b0) begin
            failures++;
            $display("FAIL new_game_req: got gs=%0d occ=%h ack=%0b exp 2 000 0",
                     game_state, board_occ, move_ack);
        end
        for (int g = 0; g < 16; g++) begin
            if (g != 0) do_new_game(1'b0);
            win_p1();
        end
        checks++;
        if (p1_wins !== 4'd15) begin
            failures++;
            $display("FAIL p1_wins_sat: got %0d exp 15", p1_wins);
        end
    endtask

    task automatic test_random();
        int who, c1, c2;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (m_state == 0 && $urandom_range(0, 3) != 0) begin
                do_new_game(1'($urandom_range(0, 1)));
            end else begin
                who = ($urandom_range(0, 3) != 0 && m_state != 0) ? m_state : $urandom_range(1, 3);
                c1 = ($urandom_range(0, 4) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
                c2 = ($urandom_range(0, 4) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
                req(who, c1, c2);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_p1_top_row();
        test_illegal();
        test_out_of_turn();
        test_back_to_back();
        test_draw();
        test_ninth_win();
        test_newgame_sat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
